// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e : transmit FSM state encoding
//   calc_div   : clock cycles per bit, rounded to nearest
//   clog2      : bits needed to hold values 0..value-1 (minimum 1)
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int calc_div(input int frequency, input int bps);
    return (frequency + bps / 2) / bps;
  endfunction

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-stream handshake between a producer and the transmitter.
//   tx_valid : producer offers tx_data
//   tx_ready : consumer can take a byte this cycle
//   tx_data  : byte to send
// A byte transfers when tx_valid & tx_ready at a rising clock edge.
interface uart_tx_buffered_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers (full when MSBs differ and the
// low bits match). Flags come straight from the pointer registers.
//   clock, reset : clock and synchronous active-high reset
//   push, din    : write request and data (ignored while full)
//   pop, dout    : read request (ignored while empty) and head-of-queue data
//   empty, full  : occupancy flags
module sync_fifo #(
  parameter int width      = 8,
  parameter int depth_log2 = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << depth_log2;

  logic [width-1:0]  mem_q [DEPTH];
  logic [depth_log2:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2:0] rd_ptr_q, rd_ptr_d;
  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[depth_log2] != rd_ptr_q[depth_log2]) &&
                 (wr_ptr_q[depth_log2-1:0] == rd_ptr_q[depth_log2-1:0]);
  assign dout  = mem_q[rd_ptr_q[depth_log2-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[depth_log2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter (1 or 2 stop bits). Bytes are queued in a
// small FIFO and sent LSB first, frames back-to-back with no idle gap.
//   clock, reset : clock and synchronous active-high reset
//   tx_if        : byte-stream input (slave side); tx_ready = FIFO not full
//   serial_out   : registered TX line, idle high
//   idle         : FIFO empty and no frame in progress
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int frequency  = 50_000_000,
  parameter int bps        = 115_200,
  parameter int depth_log2 = 2,
  parameter int stop_bits  = 1
) (
  input  logic              clock,
  input  logic              reset,
  uart_tx_buffered_if.slave tx_if,
  output logic              serial_out,
  output logic              idle
);

  localparam int DIV   = calc_div(frequency, bps);
  localparam int CNT_W = clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       STOP_LAST = 3'(stop_bits - 1);

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_full;

  sync_fifo #(
    .width      (8),
    .depth_log2 (depth_log2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_if.tx_valid),
    .din   (tx_if.tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign tx_if.tx_ready = ~fifo_full;

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dout;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level follows the current state one clock later, so the line
  // stays glitch-free and every bit still lasts exactly DIV cycles.
  always_comb begin
    serial_out_d = 1'b1;
    unique case (state_q)
      START:   serial_out_d = 1'b0;
      DATA:    serial_out_d = shift_q[0];
      default: serial_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      serial_out_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      serial_out_q <= serial_out_d;
    end
  end

  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  assign serial_out = serial_out_q;
  assign idle       = (state_q == IDLE) & fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered at DIV=16, depth 4, one stop bit.
// A line monitor decodes frames from serial_out; each test compares the
// decoded stream and timing against bytes accepted by handshake.
module tb_uart_tx_buffered;

  localparam int DIV = 16;
  localparam int FRAME = 10 * DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serial_out;
  logic idle;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .frequency  (16),
    .bps        (1),
    .depth_log2 (2),
    .stop_bits  (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_if      (bus),
    .serial_out (serial_out),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: bytes accepted by handshake, in order.
  logic [7:0]  exp_q[$];
  // Monitor output: decoded bytes, start-bit cycle, framing ok flag.
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  bit          got_ok[$];
  logic        mon_en = 1'b0;
  logic [7:0]  m_b;
  int unsigned m_t;
  bit          m_ok;

  always begin : line_monitor
    @(negedge clock);
    if (mon_en && serial_out === 1'b0) begin
      m_t  = cyc;
      m_ok = 1'b1;
      repeat (DIV / 2) @(negedge clock);
      if (serial_out !== 1'b0) m_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clock);
        m_b[i] = serial_out;
      end
      repeat (DIV) @(negedge clock);
      if (serial_out !== 1'b1) m_ok = 1'b0;
      got_q.push_back(m_b);
      got_t.push_back(m_t);
      got_ok.push_back(m_ok);
    end
  end

  // Offer a byte from the next falling edge, hold valid until accepted.
  // Returns just after the accepting edge, with t_acc = that edge's count.
  task automatic push_byte(input logic [7:0] b, output int unsigned t_acc);
    int n;
    n = 0;
    t_acc = 0;
    @(negedge clock);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    while (bus.tx_ready !== 1'b1 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 4000) begin
      tests++; fails++;
      $display("FAIL push_timeout byte=%02h tx_ready stayed %b, required 1", b, bus.tx_ready);
      bus.tx_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(posedge clock);
      #1;
      t_acc = cyc;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
    end
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((got_q.size() < exp_q.size() || idle !== 1'b1) && n < 20000) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (DIV) @(posedge clock);
    #1;
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL drain_timeout decoded=%0d required=%0d idle=%b", got_q.size(), exp_q.size(), idle);
    end
  endtask

  task automatic clear_model;
    exp_q.delete();
    got_q.delete();
    got_t.delete();
    got_ok.delete();
  endtask

  task automatic test_reset;
    int lows;
    reset = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (serial_out !== 1'b1) begin fails++; $display("FAIL reset_serial_out got=%b exp=1", serial_out); end
    tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got=%b exp=1", idle); end
    reset = 1'b0;
    lows = 0;
    repeat (200) begin
      @(posedge clock);
      #1;
      if (serial_out !== 1'b1 || idle !== 1'b1) lows++;
    end
    tests++; if (lows != 0) begin fails++; $display("FAIL reset_quiet cycles_disturbed=%0d exp=0", lows); end
  endtask

  task automatic test_single;
    int unsigned t0;
    logic [9:0] frame;
    logic expv;
    clear_model();
    push_byte(8'h55, t0);
    frame = {1'b1, 8'h55, 1'b0};
    for (int t = 1; t <= 170; t++) begin
      @(posedge clock);
      #1;
      expv = (t < 2 || t > 161) ? 1'b1 : frame[(t - 2) / DIV];
      tests++;
      if (serial_out !== expv) begin
        fails++;
        $display("FAIL single_line cycle=%0d got=%b exp=%b", t, serial_out, expv);
      end
      if (t == 100) begin
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_idle_busy got=%b exp=0", idle); end
      end
      if (t == 162) begin
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle_after got=%b exp=1", idle); end
      end
    end
    wait_drain();
    tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      fails++;
      $display("FAIL single_decode count=%0d exp=1 first=%02h exp=55", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned t0, t1;
    clear_model();
    push_byte(8'hA5, t0);
    push_byte(8'h3C, t1);
    while (cyc < t0 + 2 + 2 * FRAME + 2) begin
      @(posedge clock);
      #1;
    end
    tests++;
    if (idle !== 1'b1 || serial_out !== 1'b1) begin
      fails++; $display("FAIL b2b_end idle=%b line=%b exp idle=1 line=1", idle, serial_out);
    end
    wait_drain();
    tests++;
    if (got_q.size() != 2) begin
      fails++; $display("FAIL b2b_count got=%0d exp=2", got_q.size());
    end else begin
      tests++; if (got_q[0] !== 8'hA5 || got_q[1] !== 8'h3C) begin fails++; $display("FAIL b2b_data got=%02h,%02h exp=A5,3C", got_q[0], got_q[1]); end
      tests++; if (got_t[0] != t0 + 2) begin fails++; $display("FAIL b2b_latency got=%0d exp=%0d", got_t[0], t0 + 2); end
      tests++; if (got_t[1] - got_t[0] != FRAME) begin fails++; $display("FAIL b2b_gap got=%0d exp=%0d", got_t[1] - got_t[0], FRAME); end
      tests++; if (!got_ok[0] || !got_ok[1]) begin fails++; $display("FAIL b2b_framing ok=%b%b exp=11", got_ok[0], got_ok[1]); end
    end
  endtask

  task automatic test_fill;
    int unsigned ta[7];
    clear_model();
    for (int k = 1; k <= 5; k++) push_byte(8'(k), ta[k]);
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_low got=%b exp=0", bus.tx_ready); end
    push_byte(8'h06, ta[6]);
    for (int k = 2; k <= 5; k++) begin
      tests++;
      if (ta[k] != ta[1] + k - 1) begin fails++; $display("FAIL fill_accept byte=%0d got=%0d exp=%0d", k, ta[k], ta[1] + k - 1); end
    end
    tests++;
    if (ta[6] != ta[1] + FRAME + 2) begin fails++; $display("FAIL fill_accept6 got=%0d exp=%0d", ta[6], ta[1] + FRAME + 2); end
    wait_drain();
    tests++;
    if (got_q.size() != 6) begin
      fails++; $display("FAIL fill_count got=%0d exp=6", got_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        tests++;
        if (got_q[k] !== 8'(k + 1)) begin fails++; $display("FAIL fill_data idx=%0d got=%02h exp=%02h", k, got_q[k], 8'(k + 1)); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int unsigned t0, tx;
    int lows;
    clear_model();
    mon_en = 1'b0;
    push_byte(8'hFF, t0);
    push_byte(8'($urandom), tx);
    push_byte(8'($urandom), tx);
    while (cyc < t0 + 70) begin
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    tests++; if (serial_out !== 1'b1) begin fails++; $display("FAIL midreset_line got=%b exp=1", serial_out); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL midreset_idle got=%b exp=1", idle); end
    tests++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got=%b exp=1", bus.tx_ready); end
    lows = 0;
    repeat (400) begin
      @(posedge clock);
      #1;
      if (serial_out !== 1'b1) lows++;
    end
    tests++; if (lows != 0) begin fails++; $display("FAIL midreset_quiet low_cycles=%0d exp=0", lows); end
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_full_reject;
    int unsigned tx;
    logic [7:0] b;
    int ee_seen;
    clear_model();
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom_range(0, 8'hED));
      push_byte(b, tx);
    end
    @(negedge clock);
    tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL reject_ready got=%b exp=0", bus.tx_ready); end
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hEE;
    @(posedge clock);
    #1;
    bus.tx_valid = 1'b0;
    b = 8'($urandom_range(0, 8'hED));
    push_byte(b, tx);
    wait_drain();
    ee_seen = 0;
    foreach (got_q[k]) if (got_q[k] === 8'hEE) ee_seen++;
    tests++; if (ee_seen != 0) begin fails++; $display("FAIL reject_ee_on_line count=%0d exp=0", ee_seen); end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL reject_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        tests++;
        if (got_q[k] !== exp_q[k]) begin fails++; $display("FAIL reject_data idx=%0d got=%02h exp=%02h", k, got_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_random_stream;
    int unsigned tx;
    int bad;
    clear_model();
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(150, 250)) @(negedge clock);
      else repeat ($urandom_range(0, 3)) @(negedge clock);
      push_byte(8'($urandom), tx);
    end
    wait_drain();
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      bad = 0;
      foreach (exp_q[k]) begin
        tests++;
        if (got_q[k] !== exp_q[k] || !got_ok[k]) begin
          fails++;
          $display("FAIL random_data idx=%0d got=%02h framing=%b exp=%02h framing=1", k, got_q[k], got_ok[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid_frame();
    test_full_reject();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
